// File: rtl/control_sequencer_if.sv
// Signal bundle between the control sequencer and the datapath/memory it steers.
// memory_done is a level: a wait state keeps its outputs until memory_done is seen high at a rising edge.
interface control_sequencer_if;
  logic [4:0] ir_opcode;
  logic       memory_done;

  logic       PCout, Zlo_out, MDRout, Cout, Rout, BAout;
  logic       MARin, Zin, PCin, MDRin, IRin, Yin, Rin;
  logic       Gra, Grb, IncPC, Mem_Read, Mem_Write, Mem_enable512x32;
  logic [4:0] opcode;
  logic       run;
  logic       illegal;
  logic [3:0] dbg_state;

  modport master (
    input  ir_opcode, memory_done,
    output PCout, Zlo_out, MDRout, Cout, Rout, BAout,
    output MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    output Gra, Grb, IncPC, Mem_Read, Mem_Write, Mem_enable512x32,
    output opcode, run, illegal, dbg_state
  );

  modport slave (
    output ir_opcode, memory_done,
    input  PCout, Zlo_out, MDRout, Cout, Rout, BAout,
    input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin,
    input  Gra, Grb, IncPC, Mem_Read, Mem_Write, Mem_enable512x32,
    input  opcode, run, illegal, dbg_state
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), decode (T3), execute (T4-T7) for a small load/store/immediate ISA.
// Outputs are registered from the decode of the next state and next latched opcode.
module control_sequencer (
  input  logic               Clock,
  input  logic               clear,
  control_sequencer_if.master io_bus
);

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  typedef struct packed {
    logic       pc_out, zlo_out, mdr_out, c_out, r_out, ba_out;
    logic       mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r_in;
    logic       gra, grb, inc_pc, mem_read, mem_write, mem_en;
    logic       run, illegal;
    logic [4:0] alu;
  } ctrl_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_OR  = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00101;

  state_t     r_state, w_next_state;
  logic [4:0] r_op, w_next_op;
  ctrl_t      r_ctrl, w_ctrl;
  logic       w_mem_op;
  logic       w_defined;

  function automatic logic is_defined(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ORI, OP_ANDI, OP_NOP, OP_HALT: is_defined = 1'b1;
      default:                                                         is_defined = 1'b0;
    endcase
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_next_op    = r_op;
    case (r_state)
      S_RST: w_next_state = S_T0;
      S_T0:  w_next_state = S_T1;
      S_T1:  w_next_state = io_bus.memory_done ? S_T2 : S_T1;
      S_T2:  w_next_state = S_T3;
      S_T3: begin
        w_next_op = io_bus.ir_opcode;
        case (io_bus.ir_opcode)
          OP_HALT:                                       w_next_state = S_HALT;
          OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ORI, OP_ANDI: w_next_state = S_T4;
          default:                                       w_next_state = S_T0;
        endcase
      end
      S_T4:  w_next_state = S_T5;
      S_T5:  w_next_state = (r_op == OP_LD || r_op == OP_ST) ? S_T6 : S_T0;
      S_T6: begin
        if (r_op == OP_LD) w_next_state = io_bus.memory_done ? S_T7 : S_T6;
        else               w_next_state = S_T7;
      end
      S_T7: begin
        if (r_op == OP_ST) w_next_state = io_bus.memory_done ? S_T0 : S_T7;
        else               w_next_state = S_T0;
      end
      S_HALT:  w_next_state = S_HALT;
      default: w_next_state = S_RST;
    endcase
  end

  // Decode for the state being entered, so the registered outputs track r_state exactly.
  always_comb begin
    w_ctrl    = '0;
    w_mem_op  = (w_next_op == OP_LD) || (w_next_op == OP_ST);
    w_defined = is_defined(w_next_op);
    w_ctrl.run = (w_next_state != S_RST) && (w_next_state != S_HALT);
    case (w_next_state)
      S_T0: begin
        w_ctrl.pc_out  = 1'b1;
        w_ctrl.inc_pc  = 1'b1;
        w_ctrl.mar_in  = 1'b1;
        w_ctrl.z_in    = 1'b1;
        w_ctrl.illegal = !w_defined;
      end
      S_T1: begin
        w_ctrl.zlo_out  = 1'b1;
        w_ctrl.pc_in    = 1'b1;
        w_ctrl.mdr_in   = 1'b1;
        w_ctrl.mem_read = 1'b1;
        w_ctrl.mem_en   = 1'b1;
      end
      S_T2: begin
        w_ctrl.mdr_out = 1'b1;
        w_ctrl.ir_in   = 1'b1;
      end
      // IR is only valid during T3, so the operand-fetch strobes here cannot depend on it.
      S_T3: begin
        w_ctrl.grb    = 1'b1;
        w_ctrl.r_out  = 1'b1;
        w_ctrl.ba_out = 1'b1;
        w_ctrl.y_in   = 1'b1;
      end
      S_T4: begin
        w_ctrl.c_out = 1'b1;
        w_ctrl.z_in  = 1'b1;
        case (w_next_op)
          OP_LD, OP_LDI, OP_ST, OP_ADDI: w_ctrl.alu = ALU_ADD;
          OP_ORI:                        w_ctrl.alu = ALU_OR;
          OP_ANDI:                       w_ctrl.alu = ALU_AND;
          default:                       w_ctrl.alu = 5'b00000;
        endcase
      end
      S_T5: begin
        w_ctrl.zlo_out = 1'b1;
        w_ctrl.mar_in  = w_mem_op;
        w_ctrl.gra     = !w_mem_op;
        w_ctrl.r_in    = !w_mem_op;
      end
      S_T6: begin
        w_ctrl.mdr_in = 1'b1;
        if (w_next_op == OP_LD) begin
          w_ctrl.mem_read = 1'b1;
          w_ctrl.mem_en   = 1'b1;
        end else begin
          w_ctrl.gra    = 1'b1;
          w_ctrl.r_out  = 1'b1;
          w_ctrl.ba_out = 1'b1;
        end
      end
      S_T7: begin
        w_ctrl.mdr_out = 1'b1;
        if (w_next_op == OP_LD) begin
          w_ctrl.gra  = 1'b1;
          w_ctrl.r_in = 1'b1;
        end else begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.mem_en    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_state <= S_RST;
      r_op    <= 5'b00000;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next_state;
      r_op    <= w_next_op;
      r_ctrl  <= w_ctrl;
    end
  end

  assign io_bus.PCout            = r_ctrl.pc_out;
  assign io_bus.Zlo_out          = r_ctrl.zlo_out;
  assign io_bus.MDRout           = r_ctrl.mdr_out;
  assign io_bus.Cout             = r_ctrl.c_out;
  assign io_bus.Rout             = r_ctrl.r_out;
  assign io_bus.BAout            = r_ctrl.ba_out;
  assign io_bus.MARin            = r_ctrl.mar_in;
  assign io_bus.Zin              = r_ctrl.z_in;
  assign io_bus.PCin             = r_ctrl.pc_in;
  assign io_bus.MDRin            = r_ctrl.mdr_in;
  assign io_bus.IRin             = r_ctrl.ir_in;
  assign io_bus.Yin              = r_ctrl.y_in;
  assign io_bus.Rin              = r_ctrl.r_in;
  assign io_bus.Gra              = r_ctrl.gra;
  assign io_bus.Grb              = r_ctrl.grb;
  assign io_bus.IncPC            = r_ctrl.inc_pc;
  assign io_bus.Mem_Read         = r_ctrl.mem_read;
  assign io_bus.Mem_Write        = r_ctrl.mem_write;
  assign io_bus.Mem_enable512x32 = r_ctrl.mem_en;
  assign io_bus.opcode           = r_ctrl.alu;
  assign io_bus.run              = r_ctrl.run;
  assign io_bus.illegal          = r_ctrl.illegal;
  assign io_bus.dbg_state        = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction micro-step model feeds an expected queue; a negedge monitor compares.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic clear = 1'b0;

  control_sequencer_if io ();

  control_sequencer dut (
    .Clock  (Clock),
    .clear  (clear),
    .io_bus (io.master)
  );

  always #5 Clock = ~Clock;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;
  localparam logic [4:0] OP_ANDI = 5'b01011;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [25:0] B_PCOUT   = 26'd1 << 25;
  localparam logic [25:0] B_ZLO     = 26'd1 << 24;
  localparam logic [25:0] B_MDROUT  = 26'd1 << 23;
  localparam logic [25:0] B_COUT    = 26'd1 << 22;
  localparam logic [25:0] B_ROUT    = 26'd1 << 21;
  localparam logic [25:0] B_BAOUT   = 26'd1 << 20;
  localparam logic [25:0] B_MARIN   = 26'd1 << 19;
  localparam logic [25:0] B_ZIN     = 26'd1 << 18;
  localparam logic [25:0] B_PCIN    = 26'd1 << 17;
  localparam logic [25:0] B_MDRIN   = 26'd1 << 16;
  localparam logic [25:0] B_IRIN    = 26'd1 << 15;
  localparam logic [25:0] B_YIN     = 26'd1 << 14;
  localparam logic [25:0] B_RIN     = 26'd1 << 13;
  localparam logic [25:0] B_GRA     = 26'd1 << 12;
  localparam logic [25:0] B_GRB     = 26'd1 << 11;
  localparam logic [25:0] B_INCPC   = 26'd1 << 10;
  localparam logic [25:0] B_MRD     = 26'd1 << 9;
  localparam logic [25:0] B_MWR     = 26'd1 << 8;
  localparam logic [25:0] B_MEN     = 26'd1 << 7;
  localparam logic [25:0] B_RUN     = 26'd1 << 6;
  localparam logic [25:0] B_ILLEGAL = 26'd1 << 5;

  logic [25:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          md_tied = 1'b0;
  bit          pend_illegal = 1'b0;

  function automatic logic [25:0] dut_vec();
    return {io.PCout, io.Zlo_out, io.MDRout, io.Cout, io.Rout, io.BAout,
            io.MARin, io.Zin, io.PCin, io.MDRin, io.IRin, io.Yin, io.Rin,
            io.Gra, io.Grb, io.IncPC, io.Mem_Read, io.Mem_Write, io.Mem_enable512x32,
            io.run, io.illegal, io.opcode};
  endfunction

  function automatic bit defined_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) || (op == OP_ADDI) ||
           (op == OP_ORI) || (op == OP_ANDI) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  function automatic logic [4:0] alu_of(input logic [4:0] op);
    if (op == OP_ORI)  return 5'b00110;
    if (op == OP_ANDI) return 5'b00101;
    return 5'b00011;
  endfunction

  function automatic logic rmd();
    return md_tied ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // Monitor: every cycle with an expectation pending, compare the full control word.
  always @(negedge Clock) begin
    logic [25:0] e;
    logic [25:0] g;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = dut_vec();
      n_checks++;
      if (g !== e) begin
        n_errors++;
        $display("FAIL ctrl cycle %0d: got=%07h exp=%07h", cyc, g, e);
      end
    end
  end

  task automatic step(input logic md, input logic [25:0] e);
    exp_q.push_back(e);
    io.memory_done = md;
    @(posedge Clock);
    #1;
  endtask

  task automatic wait_state(input int w, input logic [25:0] e);
    for (int i = 0; i < w; i++) step(1'b0, e);
    step(1'b1, e);
  endtask

  task automatic run_instr(input logic [4:0] op, input int w1, input int w2, input int abort_t6);
    logic [25:0] t0;
    io.ir_opcode = op;
    t0 = B_PCOUT | B_INCPC | B_MARIN | B_ZIN | B_RUN;
    if (pend_illegal) t0 |= B_ILLEGAL;
    pend_illegal = 1'b0;
    step(rmd(), t0);
    wait_state(w1, B_ZLO | B_PCIN | B_MDRIN | B_MRD | B_MEN | B_RUN);
    step(rmd(), B_MDROUT | B_IRIN | B_RUN);
    step(rmd(), B_GRB | B_ROUT | B_BAOUT | B_YIN | B_RUN);
    if (op == OP_HALT) begin
      for (int i = 0; i < 20; i++) step(rmd(), 26'd0);
      return;
    end
    if (op == OP_NOP) return;
    if (!defined_op(op)) begin
      pend_illegal = 1'b1;
      return;
    end
    step(rmd(), B_COUT | B_ZIN | B_RUN | {21'd0, alu_of(op)});
    if (op != OP_LD && op != OP_ST) begin
      step(rmd(), B_ZLO | B_GRA | B_RIN | B_RUN);
      return;
    end
    step(rmd(), B_ZLO | B_MARIN | B_RUN);
    if (op == OP_LD) begin
      if (abort_t6 > 0) begin
        for (int i = 0; i < abort_t6; i++) step(1'b0, B_MDRIN | B_MRD | B_MEN | B_RUN);
        return;
      end
      wait_state(w2, B_MDRIN | B_MRD | B_MEN | B_RUN);
      step(rmd(), B_MDROUT | B_GRA | B_RIN | B_RUN);
    end else begin
      step(rmd(), B_MDRIN | B_GRA | B_ROUT | B_BAOUT | B_RUN);
      wait_state(w2, B_MDROUT | B_MWR | B_MEN | B_RUN);
    end
  endtask

  // Called 1 time unit after a rising edge; the clear takes effect without waiting for a clock.
  task automatic do_reset();
    clear = 1'b0;
    #1;
    n_checks++;
    if (dut_vec() !== 26'd0) begin
      n_errors++;
      $display("FAIL async_clear: got=%07h exp=%07h", dut_vec(), 26'd0);
    end
    exp_q.push_back(26'd0);
    @(posedge Clock);
    #1;
    step(rmd(), 26'd0);
    clear = 1'b1;
    step(rmd(), 26'd0);
    pend_illegal = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    logic [4:0] valid_ops[7];
    valid_ops = '{OP_LD, OP_LDI, OP_ST, OP_ADDI, OP_ORI, OP_ANDI, OP_NOP};
    io.ir_opcode   = 5'b00000;
    io.memory_done = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    do_reset();

    md_tied = 1'b1;
    run_instr(OP_LDI, 0, 0, 0);
    md_tied = 1'b0;
    run_instr(OP_LD,   1, 3, 0);
    run_instr(OP_ST,   0, 2, 0);
    run_instr(OP_ANDI, 2, 0, 0);
    run_instr(OP_ORI,  0, 0, 0);
    run_instr(OP_ADDI, 0, 0, 0);
    run_instr(OP_NOP,  1, 0, 0);
    run_instr(5'b11111, 0, 0, 0);
    run_instr(OP_LDI,  0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 8) < 7) begin
        op = valid_ops[$urandom_range(0, 6)];
      end else begin
        do op = 5'($urandom); while (defined_op(op));
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4), 0);
    end

    run_instr(OP_LD, 0, 0, 2);
    do_reset();
    run_instr(OP_LDI, 0, 0, 0);

    run_instr(OP_HALT, 0, 0, 0);
    do_reset();
    run_instr(OP_ADDI, 1, 0, 0);

    @(negedge Clock);
    #1;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port clear, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port ir_opcode, input, 5, IR[31:27] from datapath; sampled in T3 only.
REQ-004 SHALL have port memory_done, input, 1, memory access complete (level).
REQ-005 SHALL have outputs PCout, Zlo_out, MDRout, Cout, Rout, BAout, 1 each, bus drive enables.
REQ-006 SHALL have outputs MARin, Zin, PCin, MDRin, IRin, Yin, Rin, 1 each, register load enables.
REQ-007 SHALL have outputs Gra, Grb, IncPC, Mem_Read, Mem_Write, Mem_enable512x32, 1 each.
REQ-008 SHALL have output opcode, 5, ALU operation select.
REQ-009 SHALL have output run, 1, high unless halted or in reset.
REQ-010 SHALL have output illegal, 1, one-cycle pulse on undefined opcode.

Function
REQ-011 SHALL be a Moore FSM; every output registered and a pure function of the current state plus the latched opcode.
REQ-012 SHALL decode opcodes: ld=00000, ldi=00001, st=00010, addi=01001, ori=01010, andi=01011, nop=11000, halt=11011; all others undefined.
REQ-013 SHALL use ALU codes on opcode: ADD=00011 (ld, ldi, st, addi), OR=00110 (ori), AND=00101 (andi); opcode=00000 in all other states.
REQ-014 SHALL have states RST, T0..T7, HALT; RST -> T0 on first edge after clear deasserts.
REQ-015 T0: PCout, IncPC, MARin, Zin = 1; -> T1.
REQ-016 T1: Zlo_out, PCin, MDRin, Mem_Read, Mem_enable512x32 = 1; hold in T1 while memory_done=0; -> T2 on memory_done=1.
REQ-017 T2: MDRout, IRin = 1; -> T3.
REQ-018 T3: latch ir_opcode; halt -> HALT; nop -> T0; undefined -> T0 with illegal=1 for one cycle; else Grb, Rout, BAout, Yin = 1 and -> T4.
REQ-019 T4: Cout, Zin = 1, opcode per REQ-013; -> T5.
REQ-020 T5 (ld, st): Zlo_out, MARin = 1; -> T6. T5 (ldi, addi, ori, andi): Zlo_out, Gra, Rin = 1; -> T0.
REQ-021 T6 (ld): MDRin, Mem_Read, Mem_enable512x32 = 1; hold until memory_done=1; -> T7.
REQ-022 T6 (st): MDRin, Gra, Rout, BAout = 1; -> T7.
REQ-023 T7 (ld): MDRout, Gra, Rin = 1; -> T0.
REQ-024 T7 (st): MDRout, Mem_Write, Mem_enable512x32 = 1; hold until memory_done=1; -> T0.
REQ-025 SHALL never assert Mem_Read and Mem_Write together, and never assert two bus drivers (PCout, Zlo_out, MDRout, Cout, Rout) together.
REQ-026 SHALL assert Rin only together with Gra, and Rout only together with Gra or Grb.
REQ-027 HALT: all control outputs 0, run=0; remain in HALT until clear asserts.
REQ-028 memory_done already high on entry to a wait state SHALL advance after exactly one cycle in that state.
REQ-029 Every state other than RST and HALT SHALL drive run=1.

Reset
REQ-030 clear=0 SHALL immediately force state RST, all outputs 0, opcode=00000, run=0, illegal=0, including mid-instruction and during a memory wait.
REQ-031 SHALL discard the latched opcode on reset; no partial instruction resumes.

Verification
REQ-032 ldi (00001), memory_done tied 1 -> T0,T1,T2,T3,T4,T5, back to T0; opcode=00011 in T4; Gra&Rin in T5 only.
REQ-033 ld (00000), memory_done delayed 3 cycles in T6 -> T6 held 3 extra cycles with Mem_Read=1 throughout; Rin only in T7.
REQ-034 st (00010) -> Mem_Write=1 only in T7; Mem_Read=0 throughout T3..T7.
REQ-035 andi (01011), ori (01010) -> opcode 00101 and 00110 respectively in T4.
REQ-036 Opcode 11111 -> illegal pulses 1 cycle, return to T0; halt (11011) -> run=0, outputs 0 for 20 cycles.
REQ-037 clear pulsed low during T6 of ld -> outputs 0 asynchronously; restart at T0 after release.
